lsu_align_ctrl: RTL and testbench

// Load/store control stage between the EX-stage ALU result and the word-organised data memory.

---
 rtl/lsu_align_ctrl.sv | 146 ++++++++++++++
 tb/tb_lsu_align_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/lsu_align_ctrl.sv
// Load/store alignment stage: registers one request, drives word-aligned memory cycles
// with byte lanes, and returns an extended load result. Optional macro: LSU_MISALIGN_TRAP_EN.
module lsu_align_ctrl #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_re,
  input  logic                  req_we,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [2:0]            req_funct3,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ACCESS_WR = 3'd1,
    S_ACCESS_RD = 3'd2,
    S_CAPTURE   = 3'd3,
    S_ERR       = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [DM_ADDRESS-1:0] addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [2:0]            funct3_q;
  logic                  err_q;
  logic [DATA_W-1:0]     rdata_q;

  logic                  load_ok, store_ok, misalign, go_err, accept;
  logic [1:0]            o, o_ld;
  logic [3:0]            be_st;
  logic [DATA_W-1:0]     wd_st, sh, ld_ext;

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE and req_* are ignored at every other time.
  assign accept = (state_q == S_IDLE) && req_valid;

  always_comb begin
    load_ok  = req_re && !req_we &&
               (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    store_ok = req_we && !req_re && (req_funct3 inside {3'b000, 3'b001, 3'b010});
`ifdef LSU_MISALIGN_TRAP_EN
    misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
               ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
    go_err = misalign || !(load_ok || store_ok);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (go_err)       state_d = S_ERR;
          else if (load_ok) state_d = S_ACCESS_RD;
          else              state_d = S_ACCESS_WR;
        end
      end
      S_ACCESS_WR: state_d = S_DONE;
      S_ACCESS_RD: state_d = S_CAPTURE;
      S_CAPTURE:   state_d = S_DONE;
      S_ERR:       state_d = S_DONE;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Lane placement and extraction work from the latched request only.
  always_comb begin
    o     = addr_q[1:0];
    be_st = 4'b1111;
    wd_st = wdata_q;
    o_ld  = 2'b00;
    case (funct3_q[1:0])
      2'b00: begin
        be_st = 4'b0001 << o;
        wd_st = {4{wdata_q[7:0]}};
        o_ld  = o;
      end
      2'b01: begin
        be_st = 4'b0011 << {o[1], 1'b0};
        wd_st = {2{wdata_q[15:0]}};
        o_ld  = {o[1], 1'b0};
      end
      default: ;
    endcase
    sh = mem_rdata >> {o_ld, 3'b000};
    case (funct3_q)
      3'b000:  ld_ext = {{(DATA_W-8){sh[7]}}, sh[7:0]};
      3'b001:  ld_ext = {{(DATA_W-16){sh[15]}}, sh[15:0]};
      3'b100:  ld_ext = {{(DATA_W-8){1'b0}}, sh[7:0]};
      3'b101:  ld_ext = {{(DATA_W-16){1'b0}}, sh[15:0]};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        funct3_q <= req_funct3;
        err_q    <= go_err;
        rdata_q  <= '0;
      end
      if (state_q == S_CAPTURE) rdata_q <= ld_ext;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign mem_we    = (state_q == S_ACCESS_WR);
  assign mem_re    = (state_q == S_ACCESS_RD);
  assign mem_be    = mem_we ? be_st : 4'b0000;
  assign mem_wdata = mem_we ? wd_st : '0;
  assign mem_addr  = (mem_we || mem_re) ? {addr_q[DM_ADDRESS-1:2], 2'b00} : '0;
  assign rsp_valid = (state_q == S_DONE);
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_lsu_align_ctrl.sv
// Directed bench for lsu_align_ctrl: a small word memory model answers the DUT,
// every expected value below is hand-derived from the request sequence.
module tb_lsu_align_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_re, req_we;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic [8:0]  mem_addr;
  logic        mem_re, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [2:0]  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  lsu_align_ctrl #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_re(req_re), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .dbg_state(dbg_state)
  );

  // clock / memory model
  always #5 clk = ~clk;

  logic [31:0] mem [0:127];
  always @(posedge clk) begin
    if (mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr[8:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    if (mem_re) mem_rdata <= mem[mem_addr[8:2]];
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: present one request in IDLE; returns in cycle T+1
  task automatic issue(input logic re, input logic we, input logic [8:0] addr,
                       input logic [31:0] wd, input logic [2:0] f3);
    req_valid = 1'b1; req_re = re; req_we = we;
    req_addr = addr; req_wdata = wd; req_funct3 = f3;
    check("ready_at_issue", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0; req_re = 1'b0; req_we = 1'b0;
    req_wdata = 32'h0; req_funct3 = 3'b000;
  endtask

  task automatic exp_store(input string tag, input logic [8:0] maddr,
                           input logic [3:0] be, input logic [31:0] wd);
    check({tag, "_we"},    {31'd0, mem_we}, 32'd1);
    check({tag, "_re"},    {31'd0, mem_re}, 32'd0);
    check({tag, "_addr"},  {23'd0, mem_addr}, {23'd0, maddr});
    check({tag, "_be"},    {28'd0, mem_be}, {28'd0, be});
    check({tag, "_wdata"}, mem_wdata, wd);
    check({tag, "_early"}, {31'd0, rsp_valid}, 32'd0);
    tick();
    check({tag, "_we_off"}, {31'd0, mem_we}, 32'd0);
    check({tag, "_valid"},  {31'd0, rsp_valid}, 32'd1);
    check({tag, "_err"},    {31'd0, rsp_err}, 32'd0);
    check({tag, "_rdata"},  rsp_rdata, 32'h0);
    tick();
    check({tag, "_pulse"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  task automatic exp_load(input string tag, input logic [8:0] maddr, input logic [31:0] data);
    check({tag, "_re"},    {31'd0, mem_re}, 32'd1);
    check({tag, "_we"},    {31'd0, mem_we}, 32'd0);
    check({tag, "_addr"},  {23'd0, mem_addr}, {23'd0, maddr});
    check({tag, "_busy"},  {31'd0, req_ready}, 32'd0);
    tick();
    check({tag, "_re_off"}, {31'd0, mem_re}, 32'd0);
    check({tag, "_early"},  {31'd0, rsp_valid}, 32'd0);
    tick();
    check({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    check({tag, "_err"},   {31'd0, rsp_err}, 32'd0);
    check({tag, "_rdata"}, rsp_rdata, data);
    tick();
    check({tag, "_pulse"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  task automatic exp_err(input string tag);
    check({tag, "_we"},    {31'd0, mem_we}, 32'd0);
    check({tag, "_re"},    {31'd0, mem_re}, 32'd0);
    check({tag, "_be"},    {28'd0, mem_be}, 32'd0);
    check({tag, "_busy1"}, {31'd0, req_ready}, 32'd0);
    check({tag, "_early"}, {31'd0, rsp_valid}, 32'd0);
    tick();
    check({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    check({tag, "_err"},   {31'd0, rsp_err}, 32'd1);
    check({tag, "_rdata"}, rsp_rdata, 32'h0);
    check({tag, "_busy2"}, {31'd0, req_ready}, 32'd0);
    tick();
    check({tag, "_pulse"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_re = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; req_funct3 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_strobe", {30'd0, mem_re, mem_we}, 32'd0);
    check("rst_addr", {23'd0, mem_addr}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'h0);
    reset = 1'b0;
    tick();

    // word 0x010: DEADBEEF -> A5ADBEEF -> A5AD7FEF
    issue(1'b0, 1'b1, 9'h010, 32'hDEADBEEF, 3'b010); exp_store("sw010", 9'h010, 4'b1111, 32'hDEADBEEF);
    issue(1'b0, 1'b1, 9'h013, 32'h000000A5, 3'b000); exp_store("sb013", 9'h010, 4'b1000, 32'hA5A5A5A5);
    issue(1'b1, 1'b0, 9'h013, 32'h0, 3'b000);        exp_load("lb013", 9'h010, 32'hFFFFFFA5);
    issue(1'b1, 1'b0, 9'h013, 32'h0, 3'b100);        exp_load("lbu013", 9'h010, 32'h000000A5);
    issue(1'b0, 1'b1, 9'h011, 32'h1234567F, 3'b000); exp_store("sb011", 9'h010, 4'b0010, 32'h7F7F7F7F);
    issue(1'b1, 1'b0, 9'h011, 32'h0, 3'b000);        exp_load("lb011", 9'h010, 32'h0000007F);
    issue(1'b1, 1'b0, 9'h010, 32'h0, 3'b010);        exp_load("lw010", 9'h010, 32'hA5AD7FEF);

    // halfword in upper lanes of word 0x004
    issue(1'b0, 1'b1, 9'h006, 32'h00008001, 3'b001); exp_store("sh006", 9'h004, 4'b1100, 32'h80018001);
    issue(1'b1, 1'b0, 9'h006, 32'h0, 3'b001);        exp_load("lh006", 9'h004, 32'hFFFF8001);
    issue(1'b1, 1'b0, 9'h006, 32'h0, 3'b101);        exp_load("lhu006", 9'h004, 32'h00008001);

    issue(1'b0, 1'b1, 9'h008, 32'h12345678, 3'b010); exp_store("sw008", 9'h008, 4'b1111, 32'h12345678);
`ifdef LSU_MISALIGN_TRAP_EN
    issue(1'b1, 1'b0, 9'h00A, 32'h0, 3'b010);        exp_err("lw00a_trap");
    issue(1'b1, 1'b0, 9'h007, 32'h0, 3'b001);        exp_err("lh007_trap");
    issue(1'b0, 1'b1, 9'h00B, 32'hCAFEF00D, 3'b010); exp_err("sw00b_trap");
`else
    issue(1'b1, 1'b0, 9'h00A, 32'h0, 3'b010);        exp_load("lw00a_align", 9'h008, 32'h12345678);
    issue(1'b1, 1'b0, 9'h007, 32'h0, 3'b001);        exp_load("lh007_align", 9'h004, 32'hFFFF8001);
    issue(1'b0, 1'b1, 9'h00B, 32'hCAFEF00D, 3'b010); exp_store("sw00b_align", 9'h008, 4'b1111, 32'hCAFEF00D);
    issue(1'b1, 1'b0, 9'h008, 32'h0, 3'b010);        exp_load("lw008_after", 9'h008, 32'hCAFEF00D);
`endif

    // illegal strobe / funct3 combinations
    issue(1'b1, 1'b1, 9'h010, 32'h0, 3'b010);        exp_err("re_we");
    issue(1'b1, 1'b0, 9'h010, 32'h0, 3'b011);        exp_err("ld_f011");
    issue(1'b1, 1'b0, 9'h010, 32'h0, 3'b111);        exp_err("ld_f111");
    issue(1'b0, 1'b1, 9'h010, 32'h0, 3'b100);        exp_err("st_f100");
    issue(1'b0, 1'b0, 9'h010, 32'h0, 3'b000);        exp_err("no_strobe");
    issue(1'b1, 1'b0, 9'h010, 32'h0, 3'b010);        exp_load("lw010_intact", 9'h010, 32'hA5AD7FEF);

    // reset while in CAPTURE
    issue(1'b1, 1'b0, 9'h010, 32'h0, 3'b010);
    tick();
    check("cap_state", {29'd0, dbg_state}, 32'd3);
    reset = 1'b1;
    #1;
    check("arst_ready", {31'd0, req_ready}, 32'd1);
    check("arst_strobe", {30'd0, mem_re, mem_we}, 32'd0);
    check("arst_be", {28'd0, mem_be}, 32'd0);
    check("arst_addr", {23'd0, mem_addr}, 32'd0);
    check("arst_wdata", mem_wdata, 32'h0);
    check("arst_valid", {31'd0, rsp_valid}, 32'd0);
    check("arst_err", {31'd0, rsp_err}, 32'd0);
    check("arst_rdata", rsp_rdata, 32'h0);
    tick();
    check("arst_hold_valid", {31'd0, rsp_valid}, 32'd0);
    reset = 1'b0;
    tick();
    check("post_rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);
    tick();
    check("post_rst_valid2", {31'd0, rsp_valid}, 32'd0);
    issue(1'b1, 1'b0, 9'h013, 32'h0, 3'b000);        exp_load("lb013_recover", 9'h010, 32'hFFFFFFA5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
